controle_jogada: RTL and testbench

CONTROLE_JOGADA -- requirements
Module: controle_jogada

---
 rtl/controle_jogada_pkg.sv | 21 ++
 rtl/controle_jogada_detector_borda.sv | 25 ++
 rtl/controle_jogada.sv | 134 +++++++++++++
 tb/tb_controle_jogada.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_jogada_pkg.sv
// Shared state encodings and play-phase constants for the play controller.
package controle_jogada_pkg;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        ESPERA   = 4'd2,
        REGISTRA = 4'd3,
        ACERTO   = 4'd4,
        ERRO     = 4'd5,
        ESTOURO  = 4'd6,
        FIM      = 4'd7
    } estado_t;

    // ANTES: still inside the pre-update window; DEPOIS: display already advanced.
    typedef enum logic {
        ANTES  = 1'b0,
        DEPOIS = 1'b1
    } fase_t;

endpackage

// File: rtl/controle_jogada_detector_borda.sv
// Press detector: flags the cycle a button set goes from all-released to any-pressed.
module detector_borda #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         zera_as_n,
    input  logic [W-1:0] botoes,
    output logic         borda
);

    logic [W-1:0] anterior;

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            anterior <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            anterior <= botoes;
        end
    end

    // A button still held from an earlier round keeps anterior non-zero, so no new edge.
    assign borda = (botoes != '0) && (anterior == '0);

endmodule

// File: rtl/controle_jogada.sv
// Play controller: waits for a button press inside the period window, judges it
// against the expected play and walks the rounds until win, error or timeout.
module controle_jogada
    import controle_jogada_pkg::*;
#(
    parameter int W       = 4,
    parameter int RODADAS = 16,
    parameter int RW      = 4
) (
    input  logic          clock,
    input  logic          zera_as_n,
    input  logic          iniciar,
    input  logic [W-1:0]  botoes,
    input  logic [W-1:0]  esperada,
    input  logic          fim_antes,
    input  logic          fim_depois,
    output logic          zera_periodo,
    output logic          conta_periodo,
    output logic          atualiza_display,
    output logic          acertou,
    output logic          acerto_antes,
    output logic          errou,
    output logic          timeout,
    output logic          pronto,
    output logic          ganhou,
    output logic [RW-1:0] rodada,
    output logic [W-1:0]  jogada,
    output logic [3:0]    estado_db
);

    estado_t       estado, estado_prox;
    fase_t         fase, fase_prox;
    logic [RW-1:0] rodada_prox;
    logic [W-1:0]  jogada_prox;
    logic          ganhou_prox;
    logic          display_prox;
    logic          borda;

    detector_borda #(.W(W)) u_borda (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .botoes    (botoes),
        .borda     (borda)
    );

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        estado_prox  = estado;
        fase_prox    = fase;
        rodada_prox  = rodada;
        jogada_prox  = jogada;
        ganhou_prox  = ganhou;
        display_prox = 1'b0;
        case (estado)
            INICIAL: if (iniciar) begin
                estado_prox = PREPARA;
                rodada_prox = '0;
            end
            PREPARA: begin
                fase_prox   = ANTES;
                estado_prox = ESPERA;
            end
            ESPERA: begin
                // A press beats both window ends arriving in the same cycle.
                if (borda) begin
                    jogada_prox = botoes;
                    estado_prox = REGISTRA;
                end else begin
                    if (fim_antes && fase == ANTES) begin
                        display_prox = 1'b1;
                        fase_prox    = DEPOIS;
                    end
                    if (fim_depois) estado_prox = ESTOURO;
                end
            end
            REGISTRA: estado_prox = ((jogada == esperada) && $onehot(jogada)) ? ACERTO : ERRO;
            ACERTO: begin
                if (rodada == RW'(RODADAS - 1)) begin
                    ganhou_prox = 1'b1;
                    estado_prox = FIM;
                end else begin
                    rodada_prox = rodada + RW'(1);
                    estado_prox = PREPARA;
                end
            end
            ERRO, ESTOURO: begin
                ganhou_prox = 1'b0;
                estado_prox = FIM;
            end
            FIM: if (iniciar) begin
                rodada_prox = '0;
                ganhou_prox = 1'b0;
                estado_prox = PREPARA;
            end
            default: estado_prox = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            estado           <= INICIAL;
            fase             <= ANTES;
            rodada           <= '0;
            jogada           <= '0;
            ganhou           <= 1'b0;
            zera_periodo     <= 1'b0;
            conta_periodo    <= 1'b0;
            atualiza_display <= 1'b0;
            acertou          <= 1'b0;
            acerto_antes     <= 1'b0;
            errou            <= 1'b0;
            timeout          <= 1'b0;
            pronto           <= 1'b0;
        end else begin
            estado           <= estado_prox;
            fase             <= fase_prox;
            rodada           <= rodada_prox;
            jogada           <= jogada_prox;
            ganhou           <= ganhou_prox;
            zera_periodo     <= (estado_prox == PREPARA);
            conta_periodo    <= (estado_prox == ESPERA);
            atualiza_display <= display_prox;
            acertou          <= (estado_prox == ACERTO);
            acerto_antes     <= (estado_prox == ACERTO) && (fase_prox == ANTES);
            errou            <= (estado_prox == ERRO);
            timeout          <= (estado_prox == ESTOURO);
            pronto           <= (estado_prox == FIM);
        end
    end

    assign estado_db = estado;

endmodule

// File: tb/tb_controle_jogada.sv
// Randomized bench for controle_jogada: each round is planned up front and the
// expected outcome is derived from the game rules, then compared to the DUT.
module tb_controle_jogada;

    localparam int W        = 4;
    localparam int RODADAS  = 4;
    localparam int RW       = 2;
    localparam int Q_ANTES  = 24;
    localparam int Q_DEPOIS = 99;

    logic          clock = 1'b0;
    logic          zera_as_n;
    logic          iniciar;
    logic [W-1:0]  botoes;
    logic [W-1:0]  esperada;
    logic          fim_antes;
    logic          fim_depois;
    logic          zera_periodo;
    logic          conta_periodo;
    logic          atualiza_display;
    logic          acertou;
    logic          acerto_antes;
    logic          errou;
    logic          timeout;
    logic          pronto;
    logic          ganhou;
    logic [RW-1:0] rodada;
    logic [W-1:0]  jogada;
    logic [3:0]    estado_db;

    int testes = 0;
    int falhas = 0;
    int q;

    int           mdl_rodada;
    logic [W-1:0] mdl_jogada;
    bit           mdl_fim;
    bit           mdl_ganhou;

    controle_jogada #(.W(W), .RODADAS(RODADAS), .RW(RW)) dut (
        .clock            (clock),
        .zera_as_n        (zera_as_n),
        .iniciar          (iniciar),
        .botoes           (botoes),
        .esperada         (esperada),
        .fim_antes        (fim_antes),
        .fim_depois       (fim_depois),
        .zera_periodo     (zera_periodo),
        .conta_periodo    (conta_periodo),
        .atualiza_display (atualiza_display),
        .acertou          (acertou),
        .acerto_antes     (acerto_antes),
        .errou            (errou),
        .timeout          (timeout),
        .pronto           (pronto),
        .ganhou           (ganhou),
        .rodada           (rodada),
        .jogada           (jogada),
        .estado_db        (estado_db)
    );

    always #5 clock = ~clock;

    // Period counter environment, modulus 100.
    always @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n)         q <= 0;
        else if (zera_periodo)  q <= 0;
        else if (conta_periodo) q <= (q == Q_DEPOIS) ? 0 : q + 1;
    end

    assign fim_antes  = (q == Q_ANTES);
    assign fim_depois = (q == Q_DEPOIS);

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testes++;
        if (obs !== exp) begin
            falhas++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] saidas();
        return {13'd0, zera_periodo, conta_periodo, atualiza_display, acertou, acerto_antes,
                errou, timeout, pronto, ganhou, rodada, jogada, estado_db};
    endfunction

    task automatic inicia_jogo();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("inicio_zera_periodo", zera_periodo, 1);
        check("inicio_rodada", rodada, 0);
        check("inicio_ganhou", ganhou, 0);
        check("inicio_pronto", pronto, 0);
        mdl_rodada = 0;
        mdl_fim    = 0;
        mdl_ganhou = 0;
    endtask

    // One round: optional press of 'valor' when the counter reads 'alvo'; with
    // 'segura' the previous button stays held until the counter reads 'solta'.
    task automatic joga(input bit aperta, input int alvo, input logic [W-1:0] valor,
                        input logic [W-1:0] esp, input bit segura, input int solta);
        int cyc, disp, zeras, pcyc, lat;
        bit feito, apertou, ok_esp, antes_obs, ruido;
        logic [2:0] res_obs, res_esp;
        logic [RW-1:0] rodada_obs;
        ok_esp  = aperta && (valor == esp) && ($countones(valor) == 1);
        res_esp = !aperta ? 3'b001 : (ok_esp ? 3'b100 : 3'b010);
        ruido   = ($urandom_range(0, 3) == 0);
        esperada = esp;
        if (!segura) botoes = '0;

        zeras = 0;
        cyc   = 0;
        while (!conta_periodo && cyc < 10) begin
            if (zera_periodo) zeras++;
            @(negedge clock);
            cyc++;
        end
        check("espera_alcancada", conta_periodo, 1);
        check("zera_periodo_pulsos", zeras, 1);

        cyc = 0; feito = 0; apertou = 0; disp = 0; pcyc = 0; lat = 0;
        res_obs = '0; antes_obs = 0; rodada_obs = '0;
        while (!feito && cyc < 150) begin
            iniciar = ruido && (cyc == 3);
            if (segura && !apertou && q == solta) botoes = '0;
            if (aperta && !apertou && q == alvo) begin
                botoes  = valor;
                apertou = 1;
                pcyc    = cyc;
            end
            @(negedge clock);
            cyc++;
            if (atualiza_display) disp++;
            if (acertou || errou || timeout) begin
                feito      = 1;
                res_obs    = {acertou, errou, timeout};
                antes_obs  = acerto_antes;
                lat        = cyc - pcyc;
                rodada_obs = rodada;
            end
        end
        iniciar = 1'b0;

        check("resultado_chegou", feito, 1);
        check("resultado", res_obs, res_esp);
        check("acerto_antes", antes_obs, ok_esp && (alvo <= Q_ANTES));
        check("display_pulsos", disp, aperta ? int'(alvo > Q_ANTES) : 1);
        if (aperta) check("latencia", lat, 2);
        check("rodada_no_resultado", rodada_obs, mdl_rodada);
        if (aperta) mdl_jogada = valor;
        check("jogada", jogada, mdl_jogada);

        if (ok_esp && mdl_rodada < RODADAS - 1) begin
            mdl_rodada++;
        end else begin
            mdl_fim    = 1;
            mdl_ganhou = ok_esp;
        end
        if (mdl_fim) begin
            @(negedge clock);
            check("fim_pronto", pronto, 1);
            check("fim_ganhou", ganhou, mdl_ganhou);
            check("fim_rodada", rodada, mdl_rodada);
            check("fim_jogada", jogada, mdl_jogada);
        end
    endtask

    task automatic teste_reset();
        int cyc;
        inicia_jogo();
        esperada = 4'b0001;
        botoes   = '0;
        cyc = 0;
        while (!(conta_periodo && q == 50) && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("reset_q50_alcancado", q, 50);
        #1 zera_as_n = 1'b0;
        #1 check("reset_assincrono", saidas(), 0);
        @(negedge clock);
        check("reset_mantido", saidas(), 0);
        zera_as_n = 1'b1;
        repeat (5) @(negedge clock);
        check("pos_reset_quieto", saidas(), 0);
        mdl_rodada = 0;
        mdl_jogada = '0;
        mdl_fim    = 0;
        mdl_ganhou = 0;
    endtask

    initial begin
        bit           aperta, segura;
        int           alvo, solta, sorte;
        logic [W-1:0] esp, valor;

        zera_as_n = 1'b0;
        iniciar   = 1'b0;
        botoes    = '0;
        esperada  = '0;
        mdl_rodada = 0;
        mdl_jogada = '0;
        mdl_fim    = 0;
        mdl_ganhou = 0;
        #1 check("reset_inicial", saidas(), 0);
        repeat (3) @(negedge clock);
        zera_as_n = 1'b1;
        @(negedge clock);
        check("inicial_quieto", saidas(), 0);

        // Directed game: early press, late press, press on fim_depois, press on fim_antes.
        inicia_jogo();
        joga(1, 10, 4'b0010, 4'b0010, 0, -1);
        joga(1, 60, 4'b0100, 4'b0100, 0, -1);
        joga(1, 99, 4'b1000, 4'b1000, 0, -1);
        joga(1, 24, 4'b0001, 4'b0001, 0, -1);
        inicia_jogo();
        joga(0, 0, 4'b0000, 4'b0010, 0, -1);
        inicia_jogo();
        joga(1, 30, 4'b0011, 4'b0001, 0, -1);
        inicia_jogo();
        joga(1, 5, 4'b0010, 4'b0010, 0, -1);
        joga(0, 0, 4'b0000, 4'b0010, 1, -1);
        teste_reset();

        for (int g = 0; g < 25; g++) begin
            inicia_jogo();
            while (!mdl_fim) begin
                aperta = ($urandom_range(0, 9) != 0);
                alvo   = $urandom_range(0, 99);
                segura = (botoes != '0) && ($urandom_range(0, 2) == 0);
                esp    = W'(1) << $urandom_range(0, W - 1);
                if (segura && $urandom_range(0, 1) == 1) esp = botoes;
                sorte = $urandom_range(0, 9);
                if (sorte < 8)       valor = esp;
                else if (sorte == 8) valor = esp | (W'(1) << $urandom_range(0, W - 1));
                else                 valor = W'(1) << $urandom_range(0, W - 1);
                solta = -1;
                if (segura && aperta) begin
                    if (alvo == 0) alvo = 1;
                    solta = $urandom_range(0, alvo - 1);
                end else if (segura && $urandom_range(0, 1) == 1) begin
                    solta = $urandom_range(0, 99);
                end
                joga(aperta, alvo, valor, esp, segura, solta);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
